// File: rtl/rcas_arbiter.sv
// Round-robin arbiter that shares one ripple-carry adder/subtractor among REQ requesters.
// Latency: an operation accepted at edge k is presented on rsp_* in cycle k+1; one op per cycle.
// Backpressure: rsp_ready=0 holds the response bit-stable, and no new request is accepted.

module RCAS_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N:0]   c;
    logic [N-1:0] bx;

    // Subtract is A + ~B + 1. The raw carry is inverted so that c_out reads as a borrow.
    assign bx   = b ^ {N{sub}};
    assign c[0] = sub;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            assign s[i]   = a[i] ^ bx[i] ^ c[i];
            assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    endgenerate

    assign c_out = c[N] ^ sub;
endmodule

module rcas_arbiter #(
    parameter int N   = 8,
    parameter int REQ = 4,
    parameter int IW  = $clog2(REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ-1:0]   req_valid,
    input  logic [REQ*N-1:0] req_a,
    input  logic [REQ*N-1:0] req_b,
    input  logic [REQ-1:0]   req_sub,
    output logic [REQ-1:0]   req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IW-1:0]    rsp_id,
    output logic [N-1:0]     rsp_s,
    output logic             rsp_c_out,
    output logic             rsp_ovf
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          found;
    logic          can_accept;
    logic          accept;

    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          op_sub;
    logic [IW-1:0] op_id;

    // Scan starts at ptr and wraps, so the last winner has the lowest priority next time.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % REQ]) begin
                found  = 1'b1;
                winner = IW'((int'(ptr) + k) % REQ);
            end
        end
    end

    assign can_accept = rst_n && ((state == IDLE) || rsp_ready);
    assign accept     = found && can_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: begin
                if (accept)         state_nxt = HOLD;
                else if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
        rsp_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            op_id  <= '0;
        end else if (accept) begin
            ptr    <= (winner == IW'(REQ - 1)) ? '0 : winner + 1'b1;
            op_a   <= req_a[int'(winner)*N +: N];
            op_b   <= req_b[int'(winner)*N +: N];
            op_sub <= req_sub[winner];
            op_id  <= winner;
        end
    end

    RCAS_Nbit #(.N(N)) u_rcas (
        .a     (op_a),
        .b     (op_b),
        .sub   (op_sub),
        .s     (rsp_s),
        .c_out (rsp_c_out)
    );

    // The operand signs agree for an add and differ for a subtract. Overflow is a result sign that differs from A.
    assign rsp_ovf = ((op_a[N-1] ^ op_b[N-1]) == op_sub) && (rsp_s[N-1] != op_a[N-1]);
    assign rsp_id  = op_id;
endmodule

// File: tb/tb_rcas_arbiter.sv
// Directed table-driven bench for rcas_arbiter: one row per clock cycle.
// Each row holds the inputs for that cycle and the outputs expected during it.
module tb_rcas_arbiter;
    localparam int N   = 8;
    localparam int REQ = 4;
    localparam int IW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REQ-1:0]   req_valid;
    logic [REQ*N-1:0] req_a;
    logic [REQ*N-1:0] req_b;
    logic [REQ-1:0]   req_sub;
    logic [REQ-1:0]   req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [N-1:0]     rsp_s;
    logic             rsp_c_out;
    logic             rsp_ovf;

    rcas_arbiter #(.N(N), .REQ(REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_c_out (rsp_c_out),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sub;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_vld;
        logic        chk;     // compare the response fields as well as valid/ready
        logic [1:0]  e_id;
        logic [7:0]  e_s;
        logic        e_c;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] A_RR = 32'h40302010;
    localparam logic [31:0] B_RR = 32'h04030201;

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] sub, input logic rdy,
                                input logic [3:0] e_ready, input logic e_vld, input logic chk,
                                input logic [1:0] e_id, input logic [7:0] e_s, input logic e_c,
                                input logic e_ovf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.sub = sub; v.rdy = rdy;
        v.e_ready = e_ready; v.e_vld = e_vld; v.chk = chk; v.e_id = e_id;
        v.e_s = e_s; v.e_c = e_c; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row %0d %s: got %0h, expected %0h", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        rst_n     = v.rst;
        req_valid = v.vld;
        req_a     = v.a;
        req_b     = v.b;
        req_sub   = v.sub;
        rsp_ready = v.rdy;
        #2;
        n_vec++;
        cmp("req_ready", row, 32'(req_ready), 32'(v.e_ready));
        cmp("rsp_valid", row, 32'(rsp_valid), 32'(v.e_vld));
        if (v.chk) begin
            cmp("rsp_id", row, 32'(rsp_id), 32'(v.e_id));
            cmp("rsp_s", row, 32'(rsp_s), 32'(v.e_s));
            cmp("rsp_c_out", row, 32'(rsp_c_out), 32'(v.e_c));
            cmp("rsp_ovf", row, 32'(rsp_ovf), 32'(v.e_ovf));
        end
    endtask

    initial begin
        // Reset is asserted before the first edge, and req_ready must already be gated low.
        rst_n = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
        #1;
        n_vec++;
        cmp("req_ready_pre_reset", 0, 32'(req_ready), 32'h0);

        //             rst  vld      a             b             sub      rdy  e_rdy    vld  chk  id  s      c  ovf
        // Second reset cycle: every output is zero.
        tbl.push_back(mk(0, 4'hF, 32'h0,        32'h0,        4'b0000, 1, 4'b0000, 0, 1, 0, 8'h00, 0, 0));
        // Release: first grant goes to requester 0.
        tbl.push_back(mk(1, 4'hF, 32'h0,        32'h0,        4'b0000, 1, 4'b0001, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'h2, 32'h00007F00, 32'h00000100, 4'b0000, 1, 4'b0010, 1, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'h4, 32'h00050000, 32'h00070000, 4'b0100, 1, 4'b0100, 1, 1, 1, 8'h80, 0, 1));
        // ptr=3 here, so requester 2 is reached by wrapping the scan.
        tbl.push_back(mk(1, 4'h4, 32'h00800000, 32'h00010000, 4'b0100, 1, 4'b0100, 1, 1, 2, 8'hFE, 1, 0));
        tbl.push_back(mk(1, 4'h0, 32'h0,        32'h0,        4'b0000, 1, 4'b0000, 1, 1, 2, 8'h7F, 0, 1));
        tbl.push_back(mk(1, 4'h0, 32'h0,        32'h0,        4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'h8, 32'hFF000000, 32'h01000000, 4'b0000, 1, 4'b1000, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'h1, 32'h00000080, 32'h00000080, 4'b0000, 1, 4'b0001, 1, 1, 3, 8'h00, 1, 0));
        tbl.push_back(mk(1, 4'h2, 32'h0,        32'h00000100, 4'b0010, 1, 4'b0010, 1, 1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 4'h0, 32'h0,        32'h0,        4'b0000, 1, 4'b0000, 1, 1, 1, 8'hFF, 1, 0));
        tbl.push_back(mk(1, 4'h0, 32'h0,        32'h0,        4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));
        // Reset back to ptr=0, then round-robin with all four requesters valid.
        tbl.push_back(mk(0, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0001, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0010, 1, 1, 0, 8'h11, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0100, 1, 1, 1, 8'h22, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b1000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0001, 1, 1, 3, 8'h44, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 1, 4'b0010, 1, 1, 0, 8'h11, 0, 0));
        // Requester 1 drops out: the order becomes 2,3,0,2.
        tbl.push_back(mk(1, 4'hD, A_RR,         B_RR,         4'b0000, 1, 4'b0100, 1, 1, 1, 8'h22, 0, 0));
        tbl.push_back(mk(1, 4'hD, A_RR,         B_RR,         4'b0000, 1, 4'b1000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'hD, A_RR,         B_RR,         4'b0000, 1, 4'b0001, 1, 1, 3, 8'h44, 0, 0));
        tbl.push_back(mk(1, 4'hD, A_RR,         B_RR,         4'b0000, 1, 4'b0100, 1, 1, 0, 8'h11, 0, 0));
        // Backpressure for 3 cycles. ptr stays at 3, so requester 3 wins over 0 on release.
        tbl.push_back(mk(1, 4'h9, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'h9, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'h9, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'h9, A_RR,         B_RR,         4'b0000, 1, 4'b1000, 1, 1, 2, 8'h33, 0, 0));
        tbl.push_back(mk(1, 4'h0, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 1, 1, 3, 8'h44, 0, 0));
        // Reset while holding with rsp_ready=0: the response is dropped and ptr returns to 0.
        tbl.push_back(mk(0, 4'h0, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 1, 1, 3, 8'h44, 0, 0));
        tbl.push_back(mk(1, 4'h0, A_RR,         B_RR,         4'b0000, 0, 4'b0000, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'hF, A_RR,         B_RR,         4'b0000, 0, 4'b0001, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'h0, A_RR,         B_RR,         4'b0000, 1, 4'b0000, 1, 1, 0, 8'h11, 0, 0));
        tbl.push_back(mk(1, 4'h0, A_RR,         B_RR,         4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));

        for (int r = 0; r < tbl.size(); r++) apply(tbl[r], r + 1);

        // Subtract with equal operands: zero result, no borrow, no overflow. Requester 1 is next from ptr=1.
        @(negedge clk);
        req_valid = 4'h2; req_a = 32'h00005500; req_b = 32'h00005500; req_sub = 4'b0010; rsp_ready = 1'b1;
        #2;
        n_vec++;
        cmp("eq_sub_ready", 99, 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'h0;
        #2;
        n_vec++;
        cmp("eq_sub_vld", 100, 32'(rsp_valid), 32'h1);
        cmp("eq_sub_id", 100, 32'(rsp_id), 32'h1);
        cmp("eq_sub_s", 100, 32'(rsp_s), 32'h00);
        cmp("eq_sub_c", 100, 32'(rsp_c_out), 32'h0);
        cmp("eq_sub_ovf", 100, 32'(rsp_ovf), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
